// File: rtl/spi_dac_mc.sv
// Multi-channel MCP4922-class SPI DAC serialiser: one 16-bit command word per channel per load.
// Optional LDAC latch phase enabled by defining SPI_DAC_LDAC_EN.
module spi_dac_mc #(
  parameter int unsigned DW      = 10,
  parameter int unsigned NCH     = 2,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              load,
  input  logic [NCH*DW-1:0] data_in,
  input  logic [2:0]        cfg,
  output logic              busy,
  output logic              done,
  output logic              ovr,
  output logic              DAC_SDI,
  output logic              DAC_CS,
  output logic              DAC_SCK,
  output logic              DAC_LD
);

  localparam int unsigned H2 = 2 * CLK_DIV;
  localparam int unsigned CW = (H2 > 2) ? $clog2(H2) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_GAP, S_LDAC, S_FIN} state_t;

  state_t              r_state, w_state;
  logic [CW-1:0]       r_cnt, w_cnt;
  logic [3:0]          r_bit, w_bit;
  logic                r_ch, w_ch;
  logic [NCH*DW-1:0]   r_data, w_data;
  logic [2:0]          r_cfg, w_cfg;
  logic                r_busy, r_done, r_ovr, r_sdi, r_cs, r_sck;
  logic                w_busy, w_done, w_ovr, w_sdi, w_cs, w_sck, w_ld;
  logic                w_last;
  logic [2*DW-1:0]     w_pad;
  logic [DW-1:0]       w_samp;
  logic [15:0]         w_word;

  assign w_last = (r_cnt == CW'(H2 - 1));

  // Next-state logic, then next values of the registered outputs derived from it
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_bit   = r_bit;
    w_ch    = r_ch;
    w_data  = r_data;
    w_cfg   = r_cfg;
    w_pad   = '0;
    w_samp  = '0;
    w_word  = '0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    w_ovr   = load & r_busy;
    w_sdi   = 1'b0;
    w_cs    = 1'b1;
    w_sck   = 1'b0;
    w_ld    = 1'b1;

    case (r_state)
      S_IDLE, S_FIN: begin
        if (load) begin
          w_state = S_SHIFT;
          w_cnt   = '0;
          w_bit   = 4'd15;
          w_ch    = 1'b0;
          w_data  = data_in;
          w_cfg   = cfg;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_SHIFT: begin
        w_cnt = w_last ? '0 : r_cnt + CW'(1);
        if (w_last) begin
          if (r_bit == 4'd0) w_state = S_GAP;
          else               w_bit   = r_bit - 4'd1;
        end
      end
      S_GAP: begin
        w_cnt = w_last ? '0 : r_cnt + CW'(1);
        if (w_last) begin
          if (32'(r_ch) < NCH - 1) begin
            w_ch    = 1'b1;
            w_bit   = 4'd15;
            w_state = S_SHIFT;
          end else begin
`ifdef SPI_DAC_LDAC_EN
            w_state = S_LDAC;
`else
            w_state = S_FIN;
`endif
          end
        end
      end
`ifdef SPI_DAC_LDAC_EN
      S_LDAC: begin
        w_cnt = w_last ? '0 : r_cnt + CW'(1);
        if (w_last) w_state = S_FIN;
      end
`endif
      default: w_state = S_IDLE;
    endcase

    // Sample left-justified in the 12-bit field behind {channel, BUF, GA_n, SHDN_n}
    w_pad  = (2*DW)'(w_data);
    w_samp = w_ch ? w_pad[DW +: DW] : w_pad[0 +: DW];
    w_word = {w_ch, w_cfg, 12'(w_samp) << (12 - DW)};

    w_cs   = (w_state != S_SHIFT);
    w_sck  = (w_state == S_SHIFT) && (w_cnt >= CW'(CLK_DIV));
    w_sdi  = (w_state == S_SHIFT) && w_word[w_bit];
    w_busy = (w_state == S_SHIFT) || (w_state == S_GAP) || (w_state == S_LDAC);
    w_done = (w_state == S_FIN);
    w_ld   = (w_state != S_LDAC);
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_ch    <= 1'b0;
      r_data  <= '0;
      r_cfg   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
      r_sdi   <= 1'b0;
      r_cs    <= 1'b1;
      r_sck   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_ch    <= w_ch;
      r_data  <= w_data;
      r_cfg   <= w_cfg;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_ovr   <= w_ovr;
      r_sdi   <= w_sdi;
      r_cs    <= w_cs;
      r_sck   <= w_sck;
    end
  end

`ifdef SPI_DAC_LDAC_EN
  logic r_ld;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) r_ld <= 1'b1;
    else        r_ld <= w_ld;
  end

  assign DAC_LD = r_ld;
`else
  // Without a latch phase each channel updates on its own CS rise
  assign DAC_LD = 1'b0;
`endif

  assign busy    = r_busy;
  assign done    = r_done;
  assign ovr     = r_ovr;
  assign DAC_SDI = r_sdi;
  assign DAC_CS  = r_cs;
  assign DAC_SCK = r_sck;

endmodule

// File: tb/tb_spi_dac_mc.sv
// Bench for spi_dac_mc: dut_a (DW=10,NCH=2,CLK_DIV=2) and dut_b (DW=12,NCH=1,CLK_DIV=1),
// checked cycle by cycle against an arithmetic timing model plus decoded SDI words.
module tb_spi_dac_mc;

`ifdef SPI_DAC_LDAC_EN
  localparam bit LDAC = 1'b1;
`else
  localparam bit LDAC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_load, b_load;
  logic [19:0] a_data;
  logic [11:0] b_data;
  logic [2:0]  a_cfg, b_cfg;
  logic a_busy, a_done, a_ovr, a_sdi, a_cs, a_sck, a_ld;
  logic b_busy, b_done, b_ovr, b_sdi, b_cs, b_sck, b_ld;
  logic        sel;
  logic [6:0]  obs_a, obs_b, obs;

  always #5 clk = ~clk;

  spi_dac_mc #(.DW(10), .NCH(2), .CLK_DIV(2)) dut_a (
    .CLOCK_50(clk), .rst_n(rst_n), .load(a_load), .data_in(a_data), .cfg(a_cfg),
    .busy(a_busy), .done(a_done), .ovr(a_ovr), .DAC_SDI(a_sdi), .DAC_CS(a_cs),
    .DAC_SCK(a_sck), .DAC_LD(a_ld));

  spi_dac_mc #(.DW(12), .NCH(1), .CLK_DIV(1)) dut_b (
    .CLOCK_50(clk), .rst_n(rst_n), .load(b_load), .data_in(b_data), .cfg(b_cfg),
    .busy(b_busy), .done(b_done), .ovr(b_ovr), .DAC_SDI(b_sdi), .DAC_CS(b_cs),
    .DAC_SCK(b_sck), .DAC_LD(b_ld));

  // {cs, sck, sdi, ld, busy, done, ovr}
  assign obs_a = {a_cs, a_sck, a_sdi, a_ld, a_busy, a_done, a_ovr};
  assign obs_b = {b_cs, b_sck, b_sdi, b_ld, b_busy, b_done, b_ovr};
  assign obs   = sel ? obs_b : obs_a;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  function automatic logic [15:0] ref_word(input int ch, input logic [2:0] cf,
                                           input int sample, input int dw);
    return 16'((ch << 15) | (int'(cf) << 12) | (sample << (12 - dw)));
  endfunction

  function automatic int tdone_of(input bit s);
    int h, nch;
    h   = s ? 1 : 2;
    nch = s ? 1 : 2;
    return 1 + nch * 34 * h + (LDAC ? 2 * h : 0);
  endfunction

  // Expected {cs, sck, sdi, ld, busy, done} in cycle k+t after a load accepted in cycle k
  function automatic logic [5:0] model(input int t, input bit s, input logic [15:0] w0,
                                       input logic [15:0] w1);
    int h, nch, p, r, c, b;
    logic cs, sck, sdi, ld, bsy, dn;
    logic [15:0] w;
    h = s ? 1 : 2; nch = s ? 1 : 2; p = 34 * h;
    cs = 1'b1; sck = 1'b0; sdi = 1'b0; ld = LDAC; bsy = 1'b0; dn = 1'b0;
    if (t >= 1 && t <= nch * p) begin
      bsy = 1'b1;
      r = (t - 1) % p;
      c = (t - 1) / p;
      if (r < 32 * h) begin
        w   = (c == 0) ? w0 : w1;
        b   = 15 - r / (2 * h);
        cs  = 1'b0;
        sck = (r % (2 * h)) >= h;
        sdi = w[b];
      end
    end else if (t > nch * p && t < tdone_of(s)) begin
      bsy = 1'b1;
      ld  = 1'b0;
    end else if (t == tdone_of(s)) begin
      dn = 1'b1;
    end
    return {cs, sck, sdi, ld, bsy, dn};
  endfunction

  task automatic drive(input bit s, input logic ld, input logic [19:0] d, input logic [2:0] cf);
    if (s) begin b_load = ld; b_data = d[11:0]; b_cfg = cf; end
    else   begin a_load = ld; a_data = d;       a_cfg = cf; end
  endtask

  // Load in the current cycle, then watch the whole frame; optional extra load at cycle k+ovr_at
  task automatic run_frame(input string tag, input bit s, input logic [19:0] d,
                           input logic [2:0] cf, input logic [15:0] ew0, input logic [15:0] ew1,
                           input int ovr_at, input int exp_done);
    int n, ch, nbits, done_t, ovr_n, ovr_t;
    int mis [6];
    logic [15:0] wd [2];
    logic [5:0]  m;
    logic        prev_cs, prev_sck;
    n = tdone_of(s) + 4;
    ch = 0; nbits = 0; done_t = -1; ovr_n = 0; ovr_t = -1;
    wd[0] = '0; wd[1] = '0;
    foreach (mis[i]) mis[i] = 0;
    prev_cs = 1'b1; prev_sck = 1'b0;
    sel = s;
    @(negedge clk);
    drive(s, 1'b1, d, cf);
    for (int t = 1; t <= n; t++) begin
      @(negedge clk);
      if (t == 1) drive(s, 1'b0, 20'($urandom), 3'($urandom));
      m = model(t, s, ew0, ew1);
      for (int i = 0; i < 6; i++) if (obs[i+1] !== m[i]) mis[i]++;
      if (!obs[6] && obs[5] && !prev_sck && ch < 2) begin
        wd[ch] = {wd[ch][14:0], obs[4]};
        nbits++;
      end
      if (!prev_cs && obs[6]) ch++;
      if (obs[1] && done_t < 0) done_t = t;
      if (obs[0]) begin ovr_n++; ovr_t = t; end
      prev_cs = obs[6]; prev_sck = obs[5];
      if (t == ovr_at)     drive(s, 1'b1, 20'($urandom), 3'($urandom));
      if (t == ovr_at + 1) drive(s, 1'b0, 20'($urandom), 3'($urandom));
    end
    check({tag, " done-wave"}, 32'(mis[0]), 0);
    check({tag, " busy-wave"}, 32'(mis[1]), 0);
    check({tag, " ld-wave"},   32'(mis[2]), 0);
    check({tag, " sdi-wave"},  32'(mis[3]), 0);
    check({tag, " sck-wave"},  32'(mis[4]), 0);
    check({tag, " cs-wave"},   32'(mis[5]), 0);
    check({tag, " bits"},      32'(nbits), s ? 16 : 32);
    check({tag, " word0"},     32'(wd[0]), 32'(ew0));
    if (!s) check({tag, " word1"}, 32'(wd[1]), 32'(ew1));
    check({tag, " done-cycle"}, 32'(done_t), 32'(exp_done));
    check({tag, " ovr-count"},  32'(ovr_n), (ovr_at > 0) ? 1 : 0);
    if (ovr_at > 0) check({tag, " ovr-cycle"}, 32'(ovr_t), 32'(ovr_at + 1));
  endtask

  typedef struct {
    bit          s;
    logic [19:0] d;
    logic [2:0]  cf;
    logic [15:0] w0;
    logic [15:0] w1;
    int          ovr_at;
    int          done_t;
  } vec_t;

  localparam int DONE_A = LDAC ? 141 : 137;
  localparam int DONE_B = LDAC ? 37 : 35;

  initial begin
    vec_t vecs [6];
    logic [6:0] rst_exp;
    int edges, cs_low;
    logic prev_a, prev_b;
    bit s;
    logic [19:0] d;
    logic [2:0] cf;
    logic [15:0] w0, w1;
    int oa;

    vecs[0] = '{1'b0, 20'hAA955, 3'b011, 16'h3554, 16'hBAA8, 0,  DONE_A};
    vecs[1] = '{1'b0, 20'hAA955, 3'b011, 16'h3554, 16'hBAA8, 20, DONE_A};
    vecs[2] = '{1'b0, 20'h003FF, 3'b100, 16'h4FFC, 16'hC000, 0,  DONE_A};
    vecs[3] = '{1'b1, 20'h00FFF, 3'b111, 16'h7FFF, 16'h0000, 0,  DONE_B};
    vecs[4] = '{1'b1, 20'h00001, 3'b000, 16'h0001, 16'h0000, 0,  DONE_B};
    vecs[5] = '{1'b1, 20'h00A5C, 3'b010, 16'h2A5C, 16'h0000, 10, DONE_B};

    rst_exp = {1'b1, 1'b0, 1'b0, LDAC, 1'b0, 1'b0, 1'b0};
    sel = 1'b0;
    rst_n = 1'b0;
    a_load = 1'b0; b_load = 1'b0;
    a_data = '0; b_data = '0; a_cfg = '0; b_cfg = '0;
    repeat (3) @(negedge clk);
    check("reset A", 32'(obs_a), 32'(rst_exp));
    check("reset B", 32'(obs_b), 32'(rst_exp));
    rst_n = 1'b1;

    // Idle with no loads: no SCK activity, CS stays high
    edges = 0; cs_low = 0; prev_a = a_sck; prev_b = b_sck;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (a_sck !== prev_a || b_sck !== prev_b) edges++;
      if (a_cs !== 1'b1 || b_cs !== 1'b1 || a_busy || b_busy) cs_low++;
      prev_a = a_sck; prev_b = b_sck;
    end
    check("idle sck edges", 32'(edges), 0);
    check("idle cs/busy", 32'(cs_low), 0);
    check("idle A", 32'(obs_a), 32'(rst_exp));

    for (int i = 0; i < 6; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].s, vecs[i].d, vecs[i].cf,
                vecs[i].w0, vecs[i].w1, vecs[i].ovr_at, vecs[i].done_t);

    // Reset mid-SHIFT at cycle k+40, then a full frame after release
    sel = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 20'hAA955, 3'b011);
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (t == 1) drive(1'b0, 1'b0, 20'h12345, 3'b101);
    end
    check("abort pre cs", 32'(a_cs), 0);
    rst_n = 1'b0;
    #1;
    check("abort immediate", 32'(obs_a), 32'(rst_exp));
    repeat (3) @(negedge clk);
    check("abort held", 32'(obs_a), 32'(rst_exp));
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort settled", 32'(obs_a), 32'(rst_exp));
    run_frame("post-abort", 1'b0, 20'hAA955, 3'b011, 16'h3554, 16'hBAA8, 0, DONE_A);

    // Randomised frames against the reference word builder and timing model
    for (int i = 0; i < 16; i++) begin
      s  = 1'($urandom_range(0, 1));
      d  = 20'($urandom);
      cf = 3'($urandom);
      w0 = s ? ref_word(0, cf, int'(d[11:0]), 12) : ref_word(0, cf, int'(d[9:0]), 10);
      w1 = ref_word(1, cf, int'(d[19:10]), 10);
      oa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, tdone_of(s) - 1)) : 0;
      run_frame($sformatf("rnd%0d", i), s, d, cf, w0, w1, oa, tdone_of(s));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_dac_mc.md
# spi_dac_mc

Parametrised multi-channel serial DAC driver for the MCP4922-class SPI DAC on the DAC_* header. It accepts one sample per channel on a load strobe from the sample-rate tick, then serialises each channel as a 16-bit command word. It optionally finishes with a latch (LDAC) pulse so that all channel outputs update together. It is the successor to the single-channel fixed-width serialiser, adding configurable sample width, channel count, SCK rate, a busy/done handshake and overrun reporting.

## Interface

Parameters:
- DW, 10, sample width per channel, 1..12.
- NCH, 2, channel count, 1..2 (channel 0 → DAC A, channel 1 → DAC B).
- CLK_DIV, 2, sysclk cycles per SCK half-period (H), ≥1.

Ports:
- CLOCK_50  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  one-cycle sample strobe (from clk_tick).
- data_in  in  NCH*DW  samples; channel c at data_in[c*DW +: DW].
- cfg  in  3  {BUF, GA_n, SHDN_n} control bits, common to all channels.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at end of transfer.
- ovr  out  1  one-cycle pulse when a load is dropped.
- DAC_SDI  out  1  serial data, MSB first.
- DAC_CS  out  1  chip select, active low.
- DAC_SCK  out  1  serial clock, idle low.
- DAC_LD  out  1  LDAC latch strobe, active low.

## Operation

- Reset (async, any state) forces: DAC_CS=1, DAC_SCK=0, DAC_SDI=0, DAC_LD=1, busy=0, done=0, ovr=0, FSM=IDLE. Any in-flight frame is abandoned with no partial latch.
- FSM states: IDLE → SHIFT → GAP → (SHIFT for the next channel | LDAC | FIN) → IDLE.
- IDLE: load=1 snapshots data_in and cfg into internal registers, sets channel index to 0, and enters SHIFT.
- Command word for channel c: {c[0], BUF, GA_n, SHDN_n, sample, (12-DW) zeros}. The sample is left-justified in the 12-bit field.
- SHIFT: DAC_CS=0. Bits 15..0 are each held for 2H cycles: SCK low for the first H cycles, high for the second H. The DAC samples on the rising edge. After bit 0, SCK is low, CS goes high, and the FSM enters GAP.
- GAP: CS high for 2H cycles. If channels remain, increment the index and re-enter SHIFT. Otherwise go to LDAC (macro defined) or FIN.
- LDAC: DAC_LD=0 for 2H cycles, then go to FIN.
- FIN: done=1 and busy=0 for one cycle, then IDLE. A load in the FIN cycle is accepted as in IDLE.
- load while busy=1: ignored. Snapshot registers are unchanged. ovr pulses in the cycle after the strobe.
- data_in and cfg changes during a transfer have no effect.

## Timing

- load sampled at edge k (IDLE) → at k+1: busy=1, CS=0, SDI=bit15, SCK=0.
- Per channel: 32H cycles with CS low, then 2H cycles gap.
- LDAC enabled: done at k+1 + NCH·34H + 2H.
- LDAC disabled: done at k+1 + NCH·34H.
- SDI changes only on SCK falling-edge cycles, or on the CS-fall cycle. Setup and hold are each H cycles.
- Maximum sample rate: one load per transfer length + 1 cycle.

## Configuration

- SPI_DAC_LDAC_EN defined: LDAC state present. All channels update simultaneously on DAC_LD low after the last CS rise.
- SPI_DAC_LDAC_EN undefined: LDAC state removed and DAC_LD is tied to 0. Each channel updates at its own CS rise, and the transfer is 2H cycles shorter.

## Test plan

- Reset then idle: DAC_CS=1, DAC_SCK=0, DAC_LD=1, busy=0, with no SCK edges over 1000 cycles.
- DW=10, NCH=2, CLK_DIV=2, macro on, data_in={10'h2AA,10'h155}, cfg=3'b011, load at k:
  - CS low k+1..k+64, word 16'h3554 (bits 15..12 = 0011).
  - CS low k+69..k+132, word 16'hBAA8 (bits 15..12 = 1011).
  - LD low k+137..k+140, done at k+141.
- Same stimulus with the macro off: DAC_LD constantly 0, done at k+137, identical SDI words.
- Second load at k+20: ovr pulses at k+21, words unchanged, no second transfer.
- rst_n low at k+40 mid-SHIFT: outputs return to their reset values immediately. A new load after release sends a complete, correct frame.
- DW=12, NCH=1, CLK_DIV=1, data_in=12'hFFF, cfg=3'b111: word 16'h7FFF, CS low for 32 cycles, done at k+37.
